bcd_xs3_seq_ctrl: RTL and testbench
===================================

// Module: bcd_xs3_seq_ctrl
// PURPOSE
//   Sequencer that converts a packed multi-digit BCD word to Excess-3 by
//   time-sharing one 4-bit digit converter (bcd_digit_xs3), one digit per clock.
//   Sits between a BCD producer and an XS3 consumer.
//   Uses valid/ready handshakes on both sides; holds one word in flight.
// PARAMETERS
//   NUM_DIGITS  4  BCD digits per word; legal range 1..16
//   DW          4*NUM_DIGITS (localparam)  packed word width
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   producer has a word on in_bcd
//   in_ready   out  1   block can accept a word (high only in IDLE)
//   in_bcd     in   DW  packed BCD; digit 0 = bits [3:0]
//   out_valid  out  1   out_xs3/out_err valid; held until accepted
//   out_ready  in   1   consumer accepts the word
//   out_xs3    out  DW  packed XS3 result; digit i = in digit i + 3
//   out_err    out  1   one or more input digits > 9 (BCD_CHECK_EN only)
//   busy       out  1   high in CONV or DONE
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0,
//     out_xs3=0, out_err=0, busy=0, digit counter=0, capture reg=0.
//   FSM states: IDLE, CONV, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready: capture in_bcd, clear counter,
//     out_xs3 and out_err, then go to CONV. in_bcd is ignored without in_valid.
//   CONV: in_ready=0. Each cycle, feed captured digit[cnt] to bcd_digit_xs3 and
//     write the result into out_xs3 digit[cnt]. Digit 0 is converted first.
//     If cnt==NUM_DIGITS-1, go to DONE; else cnt+1.
//   DONE: out_valid=1 with stable out_xs3/out_err. On out_ready, go to IDLE and
//     drop out_valid. out_xs3 keeps its last value until the next capture.
//   Latency: out_valid rises exactly NUM_DIGITS clocks after the accepting edge.
//     Throughput: one word per NUM_DIGITS+2 clocks with out_ready held high.
//   No overlap: a new word cannot be accepted in the cycle DONE is released.
//   NUM_DIGITS=1: CONV lasts one cycle. Counter width is max(1,$clog2(NUM_DIGITS)).
//   out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//     The producer must hold in_valid until accepted.
//   Reset mid-CONV or mid-DONE drops the word; no partial output is flagged.
//   Arithmetic: each digit is a 4-bit +3 with no inter-digit carry.
//     Digits 0..9 map to 3..12.
// CONFIGURATION
//   BCD_CHECK_EN defined: digit > 9 sets the sticky out_err for that word.
//     That digit's out_xs3 nibble is forced to 4'b0000; the other digits
//     convert normally.
//   BCD_CHECK_EN undefined: out_err tied 0. Nibbles for digits > 9 are
//     unspecified and must not be checked.
// STRUCTURE
//   Package bcd_xs3_pkg: state enum (IDLE/CONV/DONE), XS3_OFFSET=4'd3,
//     BCD_MAX=4'd9, MAX_DIGITS=16.
//   Sub-module bcd_digit_xs3: combinational 4-bit BCD->XS3 gate network.
//     Exactly one instance, shared across digits by the counter mux.
//   Top holds the FSM, digit counter, capture reg and output reg.
// TESTING (NUM_DIGITS=4)
//   1. Reset, then in_bcd=16'h1234 with in_valid and out_ready=1
//      -> out_xs3=16'h4567, out_valid exactly 4 clks after accept, out_err=0.
//   2. in_bcd=16'h9999 then 16'h0000 back-to-back
//      -> 16'hCCCC then 16'h3333; in_ready low from accept until DONE released.
//   3. Backpressure: out_ready=0 for 10 clks in DONE
//      -> out_valid/out_xs3 stable, in_ready=0, second in_valid ignored.
//   4. BCD_CHECK_EN: in_bcd=16'h12A4 -> out_xs3=16'h4507, out_err=1.
//      Next word 16'h0005 -> out_err=0.
//   5. Assert rst async two clks into CONV -> outputs reach reset values
//      immediately; after release, 16'h0008 -> 16'h333B.
//   6. NUM_DIGITS=1 build: in_bcd=4'h7 -> out_xs3=4'hA, out_valid 1 clk after accept.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// Purpose: shared types and constants for the BCD -> Excess-3 sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, XS3 digit offset, largest legal BCD digit,
//   upper bound on digits per word.
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 16;

endpackage

// File: rtl/bcd_digit_xs3.sv
// Purpose: single-digit BCD -> Excess-3 converter (4-bit add of 3, no carry out).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
// Ports:
//   bcd_dat  in  4  BCD digit
//   xs3_dat  out 4  bcd_dat + 3 (mod 16)
module bcd_digit_xs3 (
  input  logic [3:0] bcd_dat,
  output logic [3:0] xs3_dat
);
  import bcd_xs3_pkg::*;

  // Ripple add of the constant 4'b0011 reduced to gates. The carry out of
  // bit 3 is dropped: digits never carry into their neighbour.
  logic c1;
  logic c2;

  assign c1         = bcd_dat[1] | bcd_dat[0];
  assign c2         = bcd_dat[2] & c1;
  assign xs3_dat[0] = ~bcd_dat[0];
  assign xs3_dat[1] = ~(bcd_dat[1] ^ bcd_dat[0]);
  assign xs3_dat[2] = bcd_dat[2] ^ c1;
  assign xs3_dat[3] = bcd_dat[3] ^ c2;

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Purpose: converts a packed NUM_DIGITS-digit BCD word to Excess-3, one digit per clock,
//   through one shared bcd_digit_xs3 instance. One word in flight at a time.
// Latency: out_valid rises NUM_DIGITS clocks after the accepting edge; one word per
//   NUM_DIGITS+2 clocks with out_ready held high.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   producer handshake; in_bcd packed BCD, digit 0 = bits [3:0]
//   out_valid/out_ready consumer handshake; out_xs3 packed XS3, out_err bad-digit flag
//   busy                high while a word is in CONV or DONE
// Build option: define BCD_CHECK_EN to flag digits > 9 on out_err and zero their
//   result nibble; without it out_err stays 0.
module bcd_xs3_seq_ctrl #(
  parameter  int NUM_DIGITS = 4,
  localparam int DW         = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_bcd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_xs3,
  output logic          out_err,
  output logic          busy
);
  import bcd_xs3_pkg::*;

  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [DW-1:0] cap_q,       cap_d;
  logic [DW-1:0] xs3_q,       xs3_d;
  logic          err_q,       err_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q,      busy_d;

  logic [3:0]    dig_bcd;
  logic [3:0]    dig_xs3;
  logic [3:0]    dig_res;

  // Digit select: the counter steers one captured nibble into the converter.
  always_comb begin
    dig_bcd = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        dig_bcd = cap_q[i*4 +: 4];
      end
    end
  end

  bcd_digit_xs3 u_digit (
    .bcd_dat (dig_bcd),
    .xs3_dat (dig_xs3)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    xs3_d       = xs3_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    dig_res     = dig_xs3;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          cap_d      = in_bcd;
          cnt_d      = '0;
          xs3_d      = '0;
          err_d      = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end

      CONV: begin
`ifdef BCD_CHECK_EN
        // Sticky for the rest of the word; the offending nibble reads as zero.
        if (dig_bcd > BCD_MAX) begin
          dig_res = 4'd0;
          err_d   = 1'b1;
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cnt_q == CW'(i)) begin
            xs3_d[i*4 +: 4] = dig_res;
          end
        end
        if (cnt_q == LAST_CNT) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        // Release goes to IDLE first, so no word is accepted on the release edge.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      xs3_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      xs3_q       <= xs3_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_xs3   = xs3_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Purpose: directed self-checking bench for bcd_xs3_seq_ctrl (4-digit and 1-digit builds).
// Latency: n/a.
// Backpressure: exercises out_ready held low in DONE.
module tb_bcd_xs3_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] in_bcd    = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_xs3;
  logic        out_err;
  logic        busy;

  // 1-digit instance
  logic        in_valid1  = 1'b0;
  logic        in_ready1;
  logic [3:0]  in_bcd1    = 4'h0;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic [3:0]  out_xs3_1;
  logic        out_err1;
  logic        busy1;

  int  total = 0;
  int  bad   = 0;
  time t_acc  = 0;
  time t_prev = 0;

  bcd_xs3_seq_ctrl #(.NUM_DIGITS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err),
    .busy      (busy)
  );

  bcd_xs3_seq_ctrl #(.NUM_DIGITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_bcd    (in_bcd1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_xs3   (out_xs3_1),
    .out_err   (out_err1),
    .busy      (busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one word through dut4; hold = extra cycles out_ready stays low in DONE.
  task automatic do_word(input logic [15:0] d, input logic [15:0] exp,
                         input logic exp_err, input int hold, input string tag);
    int n;
    in_valid = 1'b1;
    in_bcd   = d;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_rdy_wait"}, 64'(n < 50), 64'd1);
    step();
    in_valid = 1'b0;
    t_prev   = t_acc;
    t_acc    = $time;
    if (hold > 0) out_ready = 1'b0;
    chk({tag, "_rdy_conv"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_lat"},      64'(n),        64'd4);
    chk({tag, "_xs3"},      64'(out_xs3),  64'(exp));
    chk({tag, "_err"},      64'(out_err),  64'(exp_err));
    chk({tag, "_rdy_done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        in_bcd   = 16'h7777;
      end
      step();
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_xs3"}, 64'(out_xs3),   64'(exp));
      chk({tag, "_hold_rdy"}, 64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, "_rel_vld"}, 64'(out_valid), 64'd0);
    chk({tag, "_rel_rdy"}, 64'(in_ready),  64'd1);
    chk({tag, "_rel_busy"}, 64'(busy),     64'd0);
    chk({tag, "_rel_xs3"}, 64'(out_xs3),   64'(exp));
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    // Reset values, before any clock edge.
    chk("rst_rdy",  64'(in_ready),  64'd1);
    chk("rst_vld",  64'(out_valid), 64'd0);
    chk("rst_xs3",  64'(out_xs3),   64'd0);
    chk("rst_err",  64'(out_err),   64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    chk("rst1_rdy", 64'(in_ready1), 64'd1);
    chk("rst1_xs3", 64'(out_xs3_1), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // in_bcd without in_valid must not start a word.
    in_bcd = 16'h9999;
    step();
    step();
    chk("idle_busy", 64'(busy),     64'd0);
    chk("idle_rdy",  64'(in_ready), 64'd1);

    // 1: basic conversion
    do_word(16'h1234, 16'h4567, 1'b0, 0, "t1");
    // 2: back-to-back words, one per 6 clocks
    do_word(16'h9999, 16'hCCCC, 1'b0, 0, "t2a");
    chk("t2a_thru", 64'((t_acc - t_prev) / 10), 64'd6);
    do_word(16'h0000, 16'h3333, 1'b0, 0, "t2b");
    chk("t2b_thru", 64'((t_acc - t_prev) / 10), 64'd6);
    do_word(16'h5068, 16'h839B, 1'b0, 0, "t2c");
    // 3: backpressure, second in_valid during DONE ignored
    do_word(16'h4321, 16'h7654, 1'b0, 10, "t3");
    step();
    chk("t3_no_accept", 64'(busy), 64'd0);

`ifdef BCD_CHECK_EN
    // 4: bad digit flagged, nibble zeroed; flag clears for next word
    do_word(16'h12A4, 16'h4507, 1'b1, 0, "t4a");
    do_word(16'h0005, 16'h3338, 1'b0, 0, "t4b");
`endif

    // 5: async reset two clocks into CONV
    in_valid = 1'b1;
    in_bcd   = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t5_partial", 64'(out_xs3), 64'h0067);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_rdy",  64'(in_ready),  64'd1);
    chk("t5_rst_vld",  64'(out_valid), 64'd0);
    chk("t5_rst_xs3",  64'(out_xs3),   64'd0);
    chk("t5_rst_err",  64'(out_err),   64'd0);
    chk("t5_rst_busy", 64'(busy),      64'd0);
    step();
    #3 rst = 1'b0;
    step();
    do_word(16'h0008, 16'h333B, 1'b0, 0, "t5");

    // 6: single-digit build
    in_valid1 = 1'b1;
    in_bcd1   = 4'h7;
    chk("t6_rdy", 64'(in_ready1), 64'd1);
    step();
    in_valid1 = 1'b0;
    chk("t6_vld_early", 64'(out_valid1), 64'd0);
    chk("t6_busy",      64'(busy1),      64'd1);
    step();
    chk("t6_vld", 64'(out_valid1), 64'd1);
    chk("t6_xs3", 64'(out_xs3_1),  64'hA);
    chk("t6_err", 64'(out_err1),   64'd0);
    step();
    chk("t6_rel_vld", 64'(out_valid1), 64'd0);
    chk("t6_rel_rdy", 64'(in_ready1),  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
